toy_bus_req_arbiter: RTL and testbench

- Two-requester arbiter that shares the single toy bus request port between the fetch master and the LSU master.
- Sits between toy_core's fetch/lsu memory interfaces and the bus network's master input.
- Registers the granted request into a one-entry output stage.
- Records the owner of each in-flight request in an in-order tracker FIFO and steers each returning ack to that owner.

---
 rtl/toy_bus_req_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_toy_bus_req_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_bus_req_arbiter.sv
// -----------------------------------------------------------------------------
// toy_bus_req_arbiter
//
// Shares the single toy bus request port between the fetch master and the LSU
// master. A round-robin arbiter picks one requester per cycle. The winning
// request is registered into a one-entry output stage that feeds the bus.
// The owner of every accepted request is pushed into an in-order tracker
// FIFO, and each returning bus ack is steered to the owner at the FIFO head.
//
// Parameters
//   ADDR_WIDTH  request address width
//   DATA_WIDTH  request / ack data width (strobe is DATA_WIDTH/8 bits)
//   SB_WIDTH    sideband width, carried unmodified
//   OST_DEPTH   maximum outstanding requests (power of 2, >= 2)
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   fetch_req_*                  fetch request (vld/rdy + addr/data/strb/opcode/sideband)
//   fetch_ack_*                  fetch ack (vld/rdy + data/sideband)
//   lsu_req_*                    LSU request, same shape as fetch
//   lsu_ack_*                    LSU ack, same shape as fetch
//   bus_req_*                    registered downstream request
//   bus_ack_*                    downstream ack
//   err_unexp_ack                sticky: an ack arrived while nothing was outstanding
// -----------------------------------------------------------------------------
module toy_bus_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SB_WIDTH   = 10,
    parameter int OST_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    // fetch master
    input  logic                    fetch_req_vld,
    output logic                    fetch_req_rdy,
    input  logic [ADDR_WIDTH-1:0]   fetch_req_addr,
    input  logic [DATA_WIDTH-1:0]   fetch_req_data,
    input  logic [DATA_WIDTH/8-1:0] fetch_req_strb,
    input  logic                    fetch_req_opcode,
    input  logic [SB_WIDTH-1:0]     fetch_req_sideband,
    output logic                    fetch_ack_vld,
    input  logic                    fetch_ack_rdy,
    output logic [DATA_WIDTH-1:0]   fetch_ack_data,
    output logic [SB_WIDTH-1:0]     fetch_ack_sideband,

    // LSU master
    input  logic                    lsu_req_vld,
    output logic                    lsu_req_rdy,
    input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
    input  logic [DATA_WIDTH-1:0]   lsu_req_data,
    input  logic [DATA_WIDTH/8-1:0] lsu_req_strb,
    input  logic                    lsu_req_opcode,
    input  logic [SB_WIDTH-1:0]     lsu_req_sideband,
    output logic                    lsu_ack_vld,
    input  logic                    lsu_ack_rdy,
    output logic [DATA_WIDTH-1:0]   lsu_ack_data,
    output logic [SB_WIDTH-1:0]     lsu_ack_sideband,

    // downstream bus
    output logic                    bus_req_vld,
    input  logic                    bus_req_rdy,
    output logic [ADDR_WIDTH-1:0]   bus_req_addr,
    output logic [DATA_WIDTH-1:0]   bus_req_data,
    output logic [DATA_WIDTH/8-1:0] bus_req_strb,
    output logic                    bus_req_opcode,
    output logic [SB_WIDTH-1:0]     bus_req_sideband,
    input  logic                    bus_ack_vld,
    output logic                    bus_ack_rdy,
    input  logic [DATA_WIDTH-1:0]   bus_ack_data,
    input  logic [SB_WIDTH-1:0]     bus_ack_sideband,

    output logic                    err_unexp_ack
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(OST_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(OST_DEPTH);

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LSU   = 1'b1
    } owner_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    owner_e             last_grant;
    owner_e             owner_mem [OST_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    // Counts everything accepted and not yet acked, including the entry
    // still waiting in the output stage, so it equals tracker occupancy.
    logic [CNT_W-1:0]   count;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic               out_free;
    logic               accept;
    logic               fetch_win;
    logic               lsu_win;
    logic               push;
    owner_e             winner;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [STRB_WIDTH-1:0] sel_strb;
    logic                  sel_opcode;
    logic [SB_WIDTH-1:0]   sel_sideband;

    always_comb begin
        out_free = ~bus_req_vld | bus_req_rdy;
        // The full check looks at the registered count only, so a pop in
        // the same cycle does not open a slot until the next cycle.
        accept   = out_free & (count < DEPTH);

        // On a tie, the requester that did not win last time goes first.
        fetch_win = fetch_req_vld & (~lsu_req_vld   | (last_grant == OWN_LSU));
        lsu_win   = lsu_req_vld   & (~fetch_req_vld | (last_grant == OWN_FETCH));

        fetch_req_rdy = fetch_win & accept;
        lsu_req_rdy   = lsu_win & accept;
        push          = fetch_req_rdy | lsu_req_rdy;
        winner        = lsu_req_rdy ? OWN_LSU : OWN_FETCH;

        if (lsu_req_rdy) begin
            sel_addr     = lsu_req_addr;
            sel_data     = lsu_req_data;
            sel_strb     = lsu_req_strb;
            sel_opcode   = lsu_req_opcode;
            sel_sideband = lsu_req_sideband;
        end else begin
            sel_addr     = fetch_req_addr;
            sel_data     = fetch_req_data;
            sel_strb     = fetch_req_strb;
            sel_opcode   = fetch_req_opcode;
            sel_sideband = fetch_req_sideband;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: loads on accept, holds while stalled, empties when
    // drained with nothing new behind it. The owner of the entry lives in
    // the tracker, which was written on the same accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_vld      <= 1'b0;
            bus_req_addr     <= '0;
            bus_req_data     <= '0;
            bus_req_strb     <= '0;
            bus_req_opcode   <= 1'b0;
            bus_req_sideband <= '0;
        end else if (push) begin
            bus_req_vld      <= 1'b1;
            bus_req_addr     <= sel_addr;
            bus_req_data     <= sel_data;
            bus_req_strb     <= sel_strb;
            bus_req_opcode   <= sel_opcode;
            bus_req_sideband <= sel_sideband;
        end else if (bus_req_rdy) begin
            bus_req_vld      <= 1'b0;
            bus_req_addr     <= '0;
            bus_req_data     <= '0;
            bus_req_strb     <= '0;
            bus_req_opcode   <= 1'b0;
            bus_req_sideband <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Ack steering
    // ------------------------------------------------------------------
    logic   empty;
    logic   pop;
    owner_e head_owner;

    always_comb begin
        empty      = (count == '0);
        head_owner = owner_mem[rd_ptr];

        fetch_ack_vld = bus_ack_vld & ~empty & (head_owner == OWN_FETCH);
        lsu_ack_vld   = bus_ack_vld & ~empty & (head_owner == OWN_LSU);

        // With nothing outstanding the ack has no owner; swallow it so the
        // bus does not stall, and flag the error.
        if (empty) begin
            bus_ack_rdy = 1'b1;
        end else if (head_owner == OWN_FETCH) begin
            bus_ack_rdy = fetch_ack_rdy;
        end else begin
            bus_ack_rdy = lsu_ack_rdy;
        end

        pop = bus_ack_vld & bus_ack_rdy & ~empty;
    end

    assign fetch_ack_data     = bus_ack_data;
    assign fetch_ack_sideband = bus_ack_sideband;
    assign lsu_ack_data       = bus_ack_data;
    assign lsu_ack_sideband   = bus_ack_sideband;

    // ------------------------------------------------------------------
    // Tracker FIFO, round-robin pointer and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            last_grant    <= OWN_LSU;
            err_unexp_ack <= 1'b0;
            for (int i = 0; i < OST_DEPTH; i++) begin
                owner_mem[i] <= OWN_FETCH;
            end
        end else begin
            if (push) begin
                owner_mem[wr_ptr] <= winner;
                wr_ptr            <= wr_ptr + PTR_W'(1);
                last_grant        <= winner;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (bus_ack_vld & empty) begin
                err_unexp_ack <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_toy_bus_req_arbiter.sv
module tb_toy_bus_req_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 10;
    localparam int STW = DW / 8;
    localparam int OST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           fetch_req_vld = 1'b0;
    logic           fetch_req_rdy;
    logic [AW-1:0]  fetch_req_addr = '0;
    logic [DW-1:0]  fetch_req_data = '0;
    logic [STW-1:0] fetch_req_strb = '0;
    logic           fetch_req_opcode = 1'b0;
    logic [SW-1:0]  fetch_req_sideband = '0;
    logic           fetch_ack_vld;
    logic           fetch_ack_rdy = 1'b1;
    logic [DW-1:0]  fetch_ack_data;
    logic [SW-1:0]  fetch_ack_sideband;

    logic           lsu_req_vld = 1'b0;
    logic           lsu_req_rdy;
    logic [AW-1:0]  lsu_req_addr = '0;
    logic [DW-1:0]  lsu_req_data = '0;
    logic [STW-1:0] lsu_req_strb = '0;
    logic           lsu_req_opcode = 1'b0;
    logic [SW-1:0]  lsu_req_sideband = '0;
    logic           lsu_ack_vld;
    logic           lsu_ack_rdy = 1'b1;
    logic [DW-1:0]  lsu_ack_data;
    logic [SW-1:0]  lsu_ack_sideband;

    logic           bus_req_vld;
    logic           bus_req_rdy = 1'b1;
    logic [AW-1:0]  bus_req_addr;
    logic [DW-1:0]  bus_req_data;
    logic [STW-1:0] bus_req_strb;
    logic           bus_req_opcode;
    logic [SW-1:0]  bus_req_sideband;
    logic           bus_ack_vld = 1'b0;
    logic           bus_ack_rdy;
    logic [DW-1:0]  bus_ack_data = '0;
    logic [SW-1:0]  bus_ack_sideband = '0;
    logic           err_unexp_ack;

    toy_bus_req_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_WIDTH(SW), .OST_DEPTH(OST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req_vld(fetch_req_vld), .fetch_req_rdy(fetch_req_rdy),
        .fetch_req_addr(fetch_req_addr), .fetch_req_data(fetch_req_data),
        .fetch_req_strb(fetch_req_strb), .fetch_req_opcode(fetch_req_opcode),
        .fetch_req_sideband(fetch_req_sideband),
        .fetch_ack_vld(fetch_ack_vld), .fetch_ack_rdy(fetch_ack_rdy),
        .fetch_ack_data(fetch_ack_data), .fetch_ack_sideband(fetch_ack_sideband),
        .lsu_req_vld(lsu_req_vld), .lsu_req_rdy(lsu_req_rdy),
        .lsu_req_addr(lsu_req_addr), .lsu_req_data(lsu_req_data),
        .lsu_req_strb(lsu_req_strb), .lsu_req_opcode(lsu_req_opcode),
        .lsu_req_sideband(lsu_req_sideband),
        .lsu_ack_vld(lsu_ack_vld), .lsu_ack_rdy(lsu_ack_rdy),
        .lsu_ack_data(lsu_ack_data), .lsu_ack_sideband(lsu_ack_sideband),
        .bus_req_vld(bus_req_vld), .bus_req_rdy(bus_req_rdy),
        .bus_req_addr(bus_req_addr), .bus_req_data(bus_req_data),
        .bus_req_strb(bus_req_strb), .bus_req_opcode(bus_req_opcode),
        .bus_req_sideband(bus_req_sideband),
        .bus_ack_vld(bus_ack_vld), .bus_ack_rdy(bus_ack_rdy),
        .bus_ack_data(bus_ack_data), .bus_ack_sideband(bus_ack_sideband),
        .err_unexp_ack(err_unexp_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: in-flight owners as a queue (0 = fetch, 1 = lsu),
    // the request expected on the bus, and the round-robin memory.
    int             m_q[$];
    bit             m_ovld;
    logic [AW-1:0]  m_oaddr;
    logic [DW-1:0]  m_odata;
    logic [STW-1:0] m_ostrb;
    logic           m_oop;
    logic [SW-1:0]  m_osb;
    int             m_last;
    bit             m_err;

    // Downstream slave: requests seen on the bus, awaiting an ack.
    typedef struct { logic [AW-1:0] addr; int cyc; } pend_t;
    pend_t pend[$];
    bit    slave_en = 1'b0;
    int    ack_lat  = 2;
    int    ack_pct  = 100;
    int    cyc      = 0;

    // Observations collected from DUT outputs.
    logic [AW-1:0] issued[$];
    logic [DW-1:0] fetch_got[$];
    logic [DW-1:0] lsu_got[$];
    int            lsu_ack_seen;
    bit            last_facc, last_lacc;

    task automatic model_clear();
        m_q.delete();
        pend.delete();
        m_ovld = 0; m_oaddr = '0; m_odata = '0; m_ostrb = '0; m_oop = 1'b0; m_osb = '0;
        m_last = 1;
        m_err  = 0;
    endtask

    // One clock: entered and left at the falling edge with inputs set.
    task automatic step();
        bit free, room, fw, lw, ef, el, empty, efa, ela, ebr, pop;
        int head;
        if (slave_en) begin
            if (pend.size() > 0 && cyc >= pend[0].cyc + ack_lat &&
                $urandom_range(0, 99) < ack_pct) begin
                bus_ack_vld      = 1'b1;
                bus_ack_data     = pend[0].addr ^ 32'hA5A5_0000;
                bus_ack_sideband = pend[0].addr[SW-1:0];
            end else begin
                bus_ack_vld = 1'b0;
            end
        end
        #1;
        free  = !m_ovld || bus_req_rdy;
        room  = m_q.size() < OST;
        fw    = fetch_req_vld && (!lsu_req_vld || m_last == 1);
        lw    = lsu_req_vld && (!fetch_req_vld || m_last == 0);
        ef    = fw && free && room;
        el    = lw && free && room;
        empty = (m_q.size() == 0);
        head  = empty ? -1 : m_q[0];
        efa   = bus_ack_vld && head == 0;
        ela   = bus_ack_vld && head == 1;
        ebr   = empty ? 1'b1 : (head == 0 ? fetch_ack_rdy : lsu_ack_rdy);

        chk("fetch_req_rdy", fetch_req_rdy, ef);
        chk("lsu_req_rdy", lsu_req_rdy, el);
        chk("bus_req_vld", bus_req_vld, m_ovld);
        chk("bus_req_addr", bus_req_addr, m_oaddr);
        chk("bus_req_data", bus_req_data, m_odata);
        chk("bus_req_strb", bus_req_strb, m_ostrb);
        chk("bus_req_opcode", bus_req_opcode, m_oop);
        chk("bus_req_sideband", bus_req_sideband, m_osb);
        chk("fetch_ack_vld", fetch_ack_vld, efa);
        chk("lsu_ack_vld", lsu_ack_vld, ela);
        chk("bus_ack_rdy", bus_ack_rdy, ebr);
        chk("fetch_ack_data", fetch_ack_data, bus_ack_data);
        chk("lsu_ack_data", lsu_ack_data, bus_ack_data);
        chk("fetch_ack_sb", fetch_ack_sideband, bus_ack_sideband);
        chk("lsu_ack_sb", lsu_ack_sideband, bus_ack_sideband);
        chk("err_unexp_ack", err_unexp_ack, m_err);

        if (bus_req_vld === 1'b1 && bus_req_rdy) issued.push_back(bus_req_addr);
        if (fetch_ack_vld === 1'b1 && fetch_ack_rdy) fetch_got.push_back(fetch_ack_data);
        if (lsu_ack_vld === 1'b1 && lsu_ack_rdy) lsu_got.push_back(lsu_ack_data);
        if (lsu_ack_vld === 1'b1) lsu_ack_seen++;

        @(posedge clk);
        cyc++;
        pop = bus_ack_vld && ebr && !empty;
        if (bus_ack_vld && empty) m_err = 1'b1;
        if (pop) begin
            void'(m_q.pop_front());
            if (pend.size() > 0) void'(pend.pop_front());
        end
        if (m_ovld && bus_req_rdy) pend.push_back(pend_t'{m_oaddr, cyc});
        if (ef || el) begin
            m_ovld = 1;
            if (ef) begin
                m_oaddr = fetch_req_addr; m_odata = fetch_req_data; m_ostrb = fetch_req_strb;
                m_oop = fetch_req_opcode; m_osb = fetch_req_sideband;
            end else begin
                m_oaddr = lsu_req_addr; m_odata = lsu_req_data; m_ostrb = lsu_req_strb;
                m_oop = lsu_req_opcode; m_osb = lsu_req_sideband;
            end
            m_q.push_back(ef ? 0 : 1);
            m_last = ef ? 0 : 1;
        end else if (bus_req_rdy) begin
            m_ovld = 0; m_oaddr = '0; m_odata = '0; m_ostrb = '0; m_oop = 1'b0; m_osb = '0;
        end
        last_facc = ef;
        last_lacc = el;
        @(negedge clk);
    endtask

    // Asserts reset at the current falling edge and checks the outputs
    // drop without waiting for a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_bus_req_vld", bus_req_vld, 0);
        chk("rst_bus_req_addr", bus_req_addr, 0);
        chk("rst_bus_req_data", bus_req_data, 0);
        chk("rst_bus_req_strb", bus_req_strb, 0);
        chk("rst_err", err_unexp_ack, 0);
        chk("rst_fetch_ack_vld", fetch_ack_vld, 0);
        chk("rst_lsu_ack_vld", lsu_ack_vld, 0);
        model_clear();
        fetch_req_vld = 1'b0; lsu_req_vld = 1'b0; bus_ack_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bit expired;
        fetch_req_vld = 1'b0; lsu_req_vld = 1'b0;
        bus_req_rdy = 1'b1; fetch_ack_rdy = 1'b1; lsu_ack_rdy = 1'b1;
        slave_en = 1'b1; ack_lat = 0; ack_pct = 100;
        expired = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (m_q.size() == 0 && !m_ovld) begin
                expired = 1'b0;
                break;
            end
            step();
        end
        chk("drain_timeout", expired, 0);
        slave_en = 1'b0;
        bus_ack_vld = 1'b0;
    endtask

    initial begin
        int sent;
        logic [DW-1:0] g0, g1;
        model_clear();
        @(negedge clk);
        do_reset();

        // Fetch-only burst with acks two cycles after issue
        issued.delete(); fetch_got.delete(); lsu_ack_seen = 0;
        slave_en = 1'b1; ack_lat = 2; ack_pct = 100; bus_req_rdy = 1'b1;
        sent = 0;
        for (int i = 0; i < 40 && !(sent == 4 && m_q.size() == 0 && !m_ovld); i++) begin
            fetch_req_vld  = (sent < 4);
            fetch_req_addr = 32'h100 + 32'(4 * sent);
            fetch_req_data = 32'(sent);
            fetch_req_strb = 4'hF;
            step();
            if (last_facc) sent++;
        end
        fetch_req_vld = 1'b0;
        chk("s1_issued_cnt", issued.size(), 4);
        for (int k = 0; k < 4; k++) begin
            g0 = (k < issued.size()) ? issued[k] : '1;
            chk("s1_issued_addr", g0, 32'h100 + 32'(4 * k));
            g1 = (k < fetch_got.size()) ? fetch_got[k] : '1;
            chk("s1_fetch_ack_data", g1, (32'h100 + 32'(4 * k)) ^ 32'hA5A5_0000);
        end
        chk("s1_no_lsu_ack", lsu_ack_seen, 0);

        // Contention from reset: fetch wins first, then alternate
        do_reset();
        issued.delete();
        slave_en = 1'b1; ack_lat = 1;
        fetch_req_vld = 1'b1; fetch_req_addr = 32'h1000; fetch_req_data = 32'h11;
        lsu_req_vld   = 1'b1; lsu_req_addr   = 32'h2000; lsu_req_data   = 32'h22;
        for (int i = 0; i < 20 && issued.size() < 4; i++) step();
        chk("s2_issued_cnt", issued.size(), 4);
        for (int k = 0; k < 4; k++) begin
            g0 = (k < issued.size()) ? issued[k] : '1;
            chk("s2_order", g0, (k % 2 == 0) ? 32'h1000 : 32'h2000);
        end
        drain();

        // Backpressure: no acks, six LSU requests, only four may go out
        issued.delete();
        slave_en = 1'b0; bus_ack_vld = 1'b0; bus_req_rdy = 1'b1;
        lsu_req_vld = 1'b1; sent = 0;
        for (int i = 0; i < 8; i++) begin
            lsu_req_addr = 32'h300 + 32'(4 * sent);
            step();
            if (last_lacc) sent++;
        end
        chk("s3_issued_cnt", issued.size(), 4);
        #1;
        chk("s3_full_rdy", lsu_req_rdy, 0);
        bus_ack_vld = 1'b1; bus_ack_data = 32'h55; lsu_ack_rdy = 1'b1;
        #1;
        chk("s3_full_rdy_with_pop", lsu_req_rdy, 0);
        step();
        bus_ack_vld = 1'b0;
        #1;
        chk("s3_fifth_rdy", lsu_req_rdy, 1);
        step();
        if (last_lacc) sent++;
        slave_en = 1'b1; ack_lat = 0;
        for (int i = 0; i < 20 && sent < 6; i++) begin
            lsu_req_addr = 32'h300 + 32'(4 * sent);
            step();
            if (last_lacc) sent++;
        end
        drain();
        chk("s3_total_issued", issued.size(), 6);

        // Interleaved returns: grants fetch, lsu, lsu, fetch
        slave_en = 1'b0; bus_ack_vld = 1'b0; bus_req_rdy = 1'b1;
        fetch_req_vld = 1'b1; lsu_req_vld = 1'b0; fetch_req_addr = 32'h40; step();
        fetch_req_vld = 1'b0; lsu_req_vld = 1'b1; lsu_req_addr = 32'h50; step();
        lsu_req_addr = 32'h54; step();
        lsu_req_vld = 1'b0; fetch_req_vld = 1'b1; fetch_req_addr = 32'h44; step();
        fetch_req_vld = 1'b0; step();
        fetch_got.delete(); lsu_got.delete();
        bus_ack_vld = 1'b1; bus_ack_data = 32'hA; step();
        bus_ack_data = 32'hB; lsu_ack_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s4_hold_bus_ack_rdy", bus_ack_rdy, 0);
            chk("s4_hold_lsu_ack_vld", lsu_ack_vld, 1);
            chk("s4_hold_lsu_ack_data", lsu_ack_data, 32'hB);
            step();
        end
        lsu_ack_rdy = 1'b1; step();
        bus_ack_data = 32'hC; step();
        bus_ack_data = 32'hD; step();
        bus_ack_vld = 1'b0; step();
        chk("s4_fetch_cnt", fetch_got.size(), 2);
        chk("s4_lsu_cnt", lsu_got.size(), 2);
        g0 = (fetch_got.size() > 0) ? fetch_got[0] : '1;
        g1 = (fetch_got.size() > 1) ? fetch_got[1] : '1;
        chk("s4_fetch_0", g0, 32'hA);
        chk("s4_fetch_1", g1, 32'hD);
        g0 = (lsu_got.size() > 0) ? lsu_got[0] : '1;
        g1 = (lsu_got.size() > 1) ? lsu_got[1] : '1;
        chk("s4_lsu_0", g0, 32'hB);
        chk("s4_lsu_1", g1, 32'hC);

        // Stall hold with an LSU store pending
        bus_req_rdy = 1'b0;
        lsu_req_vld = 1'b1; lsu_req_addr = 32'h400; lsu_req_data = 32'hDEAD_BEEF;
        lsu_req_strb = 4'hF; lsu_req_opcode = 1'b1; lsu_req_sideband = 10'h3C;
        step();
        lsu_req_vld = 1'b0; fetch_req_vld = 1'b1; fetch_req_addr = 32'h500;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s5_hold_data", bus_req_data, 32'hDEAD_BEEF);
            chk("s5_hold_strb", bus_req_strb, 4'hF);
            chk("s5_hold_addr", bus_req_addr, 32'h400);
            chk("s5_fetch_rdy", fetch_req_rdy, 0);
            step();
        end
        bus_req_rdy = 1'b1; step();
        drain();

        // Unexpected ack with the tracker empty
        bus_ack_vld = 1'b1; bus_ack_data = 32'h77; fetch_ack_rdy = 1'b0; lsu_ack_rdy = 1'b0;
        #1;
        chk("s6_unexp_rdy", bus_ack_rdy, 1);
        chk("s6_unexp_fetch_vld", fetch_ack_vld, 0);
        chk("s6_unexp_lsu_vld", lsu_ack_vld, 0);
        step();
        bus_ack_vld = 1'b0; fetch_ack_rdy = 1'b1; lsu_ack_rdy = 1'b1;
        step(); step();
        chk("s6_err_sticky", err_unexp_ack, 1);

        // Reset with two requests in flight
        fetch_req_vld = 1'b1; fetch_req_addr = 32'h600; step();
        fetch_req_vld = 1'b0; lsu_req_vld = 1'b1; lsu_req_addr = 32'h700; step();
        lsu_req_vld = 1'b0;
        do_reset();
        bus_ack_vld = 1'b1; fetch_ack_rdy = 1'b0; lsu_ack_rdy = 1'b0;
        #1;
        chk("s6_post_rst_rdy", bus_ack_rdy, 1);
        chk("s6_post_rst_fetch_vld", fetch_ack_vld, 0);
        chk("s6_post_rst_lsu_vld", lsu_ack_vld, 0);
        bus_ack_vld = 1'b0; fetch_ack_rdy = 1'b1; lsu_ack_rdy = 1'b1;
        @(negedge clk);

        // Randomized traffic against the model
        slave_en = 1'b1; ack_lat = 1; ack_pct = 60;
        last_facc = 1'b0; last_lacc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(fetch_req_vld && !last_facc)) begin
                fetch_req_vld      = 1'($urandom_range(0, 1));
                fetch_req_addr     = $urandom;
                fetch_req_data     = $urandom;
                fetch_req_strb     = STW'($urandom_range(0, 15));
                fetch_req_opcode   = 1'($urandom_range(0, 1));
                fetch_req_sideband = SW'($urandom_range(0, 1023));
            end
            if (!(lsu_req_vld && !last_lacc)) begin
                lsu_req_vld      = 1'($urandom_range(0, 1));
                lsu_req_addr     = $urandom;
                lsu_req_data     = $urandom;
                lsu_req_strb     = STW'($urandom_range(0, 15));
                lsu_req_opcode   = 1'($urandom_range(0, 1));
                lsu_req_sideband = SW'($urandom_range(0, 1023));
            end
            bus_req_rdy   = ($urandom_range(0, 9) < 7);
            fetch_ack_rdy = ($urandom_range(0, 9) < 7);
            lsu_ack_rdy   = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
